// File: rtl/l2_read_arbiter.sv
// Shares one L2 read channel between the instruction and data caches: arbitrates addresses,
// records owner order, steers each returning burst. Define L2_ARB_DAT_PRIORITY_EN for fixed DAT priority.
module l2_read_arbiter #(
  parameter int W = 7,
  parameter int B = 9,
  parameter int D = 2,
  localparam int BW    = 1 << W,
  localparam int CW    = B - W,
  localparam int BURST = 1 << CW,
  localparam int DEPTH = 1 << D
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [29:0]   INS_ADDR,
  input  logic          INS_ADDR_VALID,
  output logic          INS_ADDR_READY,
  output logic [BW-1:0] INS_DATA,
  output logic          INS_DATA_VALID,
  input  logic          INS_DATA_READY,
  input  logic [29:0]   DAT_ADDR,
  input  logic          DAT_ADDR_VALID,
  output logic          DAT_ADDR_READY,
  output logic [BW-1:0] DAT_DATA,
  output logic          DAT_DATA_VALID,
  input  logic          DAT_DATA_READY,
  output logic [29:0]   L2_ADDR,
  output logic          L2_ADDR_VALID,
  input  logic          L2_ADDR_READY,
  input  logic [BW-1:0] L2_DATA,
  input  logic          L2_DATA_VALID,
  output logic          L2_DATA_READY,
  output logic [D:0]    OUTSTANDING,
  output logic          PROTO_ERR
);

  logic [DEPTH-1:0] owner_fifo;
  logic [D-1:0]     wr_ptr, rd_ptr;
  logic [D:0]       count;
  logic [CW-1:0]    beat_cnt;
  logic             lock_q, lock_own;
  logic             proto_err_q;
  logic             gnt, req_valid, full, empty, owner;
  logic             addr_hs, beat_hs, push, pop;

  assign full  = (count == (D+1)'(DEPTH));
  assign empty = (count == '0);

`ifdef L2_ARB_DAT_PRIORITY_EN
  always_comb begin
    gnt = DAT_ADDR_VALID;
    if (lock_q) gnt = lock_own;
  end
`else
  logic prio_q;

  always_comb begin
    gnt = DAT_ADDR_VALID;
    if (lock_q)                                gnt = lock_own;
    else if (INS_ADDR_VALID && DAT_ADDR_VALID) gnt = prio_q;
  end

  // priority goes to the loser of each accepted request
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          prio_q <= 1'b0;
    else if (addr_hs) prio_q <= ~gnt;
  end
`endif

  assign req_valid      = gnt ? DAT_ADDR_VALID : INS_ADDR_VALID;
  assign L2_ADDR        = gnt ? DAT_ADDR : INS_ADDR;
  assign L2_ADDR_VALID  = req_valid & ~full & ~RST;
  assign INS_ADDR_READY = ~gnt & L2_ADDR_READY & ~full & ~RST;
  assign DAT_ADDR_READY =  gnt & L2_ADDR_READY & ~full & ~RST;
  assign addr_hs        = L2_ADDR_VALID & L2_ADDR_READY;

  // hold the grant while a request is stalled so L2_ADDR does not change under it
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_q   <= 1'b0;
      lock_own <= 1'b0;
    end else begin
      lock_q   <= L2_ADDR_VALID & ~L2_ADDR_READY;
      lock_own <= gnt;
    end
  end

  assign owner          = owner_fifo[rd_ptr];
  assign INS_DATA       = L2_DATA;
  assign DAT_DATA       = L2_DATA;
  assign INS_DATA_VALID = L2_DATA_VALID & ~empty & ~owner;
  assign DAT_DATA_VALID = L2_DATA_VALID & ~empty &  owner;
  // with nothing outstanding the beat is swallowed so a misbehaving L2 cannot wedge
  assign L2_DATA_READY  = ~RST & (empty | (owner ? DAT_DATA_READY : INS_DATA_READY));
  assign beat_hs        = L2_DATA_VALID & L2_DATA_READY & ~empty;
  assign push           = addr_hs;
  assign pop            = beat_hs & (beat_cnt == CW'(BURST - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner_fifo <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      beat_cnt   <= '0;
    end else begin
      if (push) begin
        owner_fifo[wr_ptr] <= gnt;
        wr_ptr             <= wr_ptr + 1'b1;
      end
      if (pop)     rd_ptr   <= rd_ptr + 1'b1;
      if (beat_hs) beat_cnt <= beat_cnt + 1'b1;
      count <= count + (D+1)'(push) - (D+1)'(pop);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                         proto_err_q <= 1'b0;
    else if (L2_DATA_VALID && empty) proto_err_q <= 1'b1;
  end

  assign OUTSTANDING = count;
  assign PROTO_ERR   = proto_err_q;

endmodule

// File: tb/tb_l2_read_arbiter.sv
// Directed bench for l2_read_arbiter: stimulus pushes expected grants/beats, a negedge monitor
// pops and compares on every handshake.
module tb_l2_read_arbiter;
  localparam int BW = 128;

  logic          CLK = 1'b0, RST = 1'b1;
  logic [29:0]   INS_ADDR = '0, DAT_ADDR = '0, L2_ADDR;
  logic          INS_ADDR_VALID = 0, DAT_ADDR_VALID = 0, INS_ADDR_READY, DAT_ADDR_READY;
  logic [BW-1:0] INS_DATA, DAT_DATA, L2_DATA = '0;
  logic          INS_DATA_VALID, DAT_DATA_VALID, INS_DATA_READY = 1, DAT_DATA_READY = 1;
  logic          L2_ADDR_VALID, L2_ADDR_READY = 0, L2_DATA_VALID = 0, L2_DATA_READY;
  logic [2:0]    OUTSTANDING;
  logic          PROTO_ERR;

  l2_read_arbiter dut (
    .CLK(CLK), .RST(RST),
    .INS_ADDR(INS_ADDR), .INS_ADDR_VALID(INS_ADDR_VALID), .INS_ADDR_READY(INS_ADDR_READY),
    .INS_DATA(INS_DATA), .INS_DATA_VALID(INS_DATA_VALID), .INS_DATA_READY(INS_DATA_READY),
    .DAT_ADDR(DAT_ADDR), .DAT_ADDR_VALID(DAT_ADDR_VALID), .DAT_ADDR_READY(DAT_ADDR_READY),
    .DAT_DATA(DAT_DATA), .DAT_DATA_VALID(DAT_DATA_VALID), .DAT_DATA_READY(DAT_DATA_READY),
    .L2_ADDR(L2_ADDR), .L2_ADDR_VALID(L2_ADDR_VALID), .L2_ADDR_READY(L2_ADDR_READY),
    .L2_DATA(L2_DATA), .L2_DATA_VALID(L2_DATA_VALID), .L2_DATA_READY(L2_DATA_READY),
    .OUTSTANDING(OUTSTANDING), .PROTO_ERR(PROTO_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic own; logic [29:0]   addr; } gnt_t;
  typedef struct packed { logic own; logic [BW-1:0] data; } beat_t;

  gnt_t  exp_grant[$];
  beat_t exp_beat[$];
  logic  owner_q[$];
  gnt_t  g;
  beat_t bt;
  int    checks = 0, errors = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic exp_req(input logic own, input logic [29:0] addr);
    exp_grant.push_back('{own, addr});
    owner_q.push_back(own);
  endtask

  task automatic send_beat(input logic exp_en, input logic own, input logic [BW-1:0] d);
    int n = 0;
    L2_DATA = d;
    L2_DATA_VALID = 1'b1;
    if (exp_en) exp_beat.push_back('{own, d});
    #1;
    while (!L2_DATA_READY && n < 50) begin tick(); n++; end
    if (n == 50) chk("beat_ready_timeout", 1'b0, 1'b1);
    tick();
    L2_DATA_VALID = 1'b0;
  endtask

  task automatic burst(input logic [31:0] base);
    logic own = owner_q.pop_front();
    for (int i = 0; i < 4; i++) send_beat(1'b1, own, {4{base + 32'(i)}});
  endtask

  // scoreboard monitor
  always @(negedge CLK) if (!RST) begin
    if (L2_ADDR_VALID && L2_ADDR_READY) begin
      if (exp_grant.size() == 0) chk("grant_unexpected", L2_ADDR, '1);
      else begin
        g = exp_grant.pop_front();
        chk("grant_owner", DAT_ADDR_READY, g.own);
        chk("grant_addr", L2_ADDR, g.addr);
        chk("grant_onehot", INS_ADDR_READY ^ DAT_ADDR_READY, 1'b1);
      end
    end
    if (INS_DATA_VALID && DAT_DATA_VALID) chk("both_data_valid", 1'b1, 1'b0);
    else if ((INS_DATA_VALID && INS_DATA_READY) || (DAT_DATA_VALID && DAT_DATA_READY)) begin
      if (exp_beat.size() == 0) chk("beat_unexpected", L2_DATA, '1);
      else begin
        bt = exp_beat.pop_front();
        chk("beat_owner", DAT_DATA_VALID, bt.own);
        chk("beat_data", DAT_DATA_VALID ? DAT_DATA : INS_DATA, bt.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic own;
    // reset: requests and beats present must not leak through
    INS_ADDR_VALID = 1; L2_ADDR_READY = 1; L2_DATA_VALID = 1;
    tick(); tick();
    chk("rst_l2_addr_valid", L2_ADDR_VALID, 0);
    chk("rst_ins_addr_ready", INS_ADDR_READY, 0);
    chk("rst_dat_addr_ready", DAT_ADDR_READY, 0);
    chk("rst_l2_data_ready", L2_DATA_READY, 0);
    chk("rst_data_valid", {INS_DATA_VALID, DAT_DATA_VALID}, 0);
    chk("rst_outstanding", OUTSTANDING, 0);
    chk("rst_proto_err", PROTO_ERR, 0);
    INS_ADDR_VALID = 0; L2_DATA_VALID = 0; RST = 0;
    tick();

    // single INS request, 4-beat return
    INS_ADDR = 30'h100; exp_req(1'b0, 30'h100);
    INS_ADDR_VALID = 1; #1;
    chk("t1_ins_ready", INS_ADDR_READY, 1);
    tick(); INS_ADDR_VALID = 0;
    chk("t1_outstanding", OUTSTANDING, 1);
    own = owner_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      send_beat(1'b1, own, {4{32'h1000 + 32'(i)}});
      chk("t1_outstanding_beat", OUTSTANDING, (i < 3) ? 1 : 0);
    end

    // both requesting every cycle until full, then first burst frees a slot
    RST = 1; tick(); RST = 0; owner_q.delete();
    INS_ADDR = 30'h200; DAT_ADDR = 30'h300;
`ifdef L2_ARB_DAT_PRIORITY_EN
    for (int i = 0; i < 4; i++) exp_req(1'b1, 30'h300);
`else
    exp_req(1'b0, 30'h200); exp_req(1'b1, 30'h300);
    exp_req(1'b0, 30'h200); exp_req(1'b1, 30'h300);
`endif
    INS_ADDR_VALID = 1; DAT_ADDR_VALID = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("full_l2_addr_valid", L2_ADDR_VALID, 0);
    chk("full_addr_ready", {INS_ADDR_READY, DAT_ADDR_READY}, 0);
    chk("full_outstanding", OUTSTANDING, 4);
    burst(32'h2000);
    chk("after_pop_addr_valid", L2_ADDR_VALID, 1);
`ifdef L2_ARB_DAT_PRIORITY_EN
    exp_req(1'b1, 30'h300);
`else
    exp_req(1'b0, 30'h200);
`endif
    tick(); INS_ADDR_VALID = 0; DAT_ADDR_VALID = 0;
    chk("refill_outstanding", OUTSTANDING, 4);

    // owner stalls mid-burst: beat held, counter must not advance
    own = owner_q.pop_front();
    send_beat(1'b1, own, {4{32'h3000}});
    if (own) DAT_DATA_READY = 0; else INS_DATA_READY = 0;
    L2_DATA = {4{32'h3001}}; L2_DATA_VALID = 1; exp_beat.push_back('{own, {4{32'h3001}}});
    #1;
    chk("stall_l2_data_ready", L2_DATA_READY, 0);
    chk("stall_owner_valid", own ? DAT_DATA_VALID : INS_DATA_VALID, 1);
    tick(); tick(); tick();
    chk("stall_outstanding", OUTSTANDING, 4);
    DAT_DATA_READY = 1; INS_DATA_READY = 1;
    tick(); L2_DATA_VALID = 0;
    send_beat(1'b1, own, {4{32'h3002}});
    chk("stall_before_last", OUTSTANDING, 4);
    send_beat(1'b1, own, {4{32'h3003}});
    chk("stall_done_outstanding", OUTSTANDING, 3);
    burst(32'h4000); burst(32'h5000); burst(32'h6000);
    chk("drain_outstanding", OUTSTANDING, 0);

    // grant lock: stalled INS request keeps the bus when DAT (holding priority) arrives
    L2_ADDR_READY = 0; INS_ADDR = 30'h440; DAT_ADDR = 30'h550;
    INS_ADDR_VALID = 1; tick();
    DAT_ADDR_VALID = 1; #1;
    chk("lock_addr", L2_ADDR, 30'h440);
    chk("lock_dat_ready", DAT_ADDR_READY, 0);
    tick();
    chk("lock_addr_hold", L2_ADDR, 30'h440);
    exp_req(1'b0, 30'h440); exp_req(1'b1, 30'h550);
    L2_ADDR_READY = 1; tick(); INS_ADDR_VALID = 0;
    tick(); DAT_ADDR_VALID = 0;
    chk("lock_outstanding", OUTSTANDING, 2);
    burst(32'h7000); burst(32'h8000);
    chk("lock_drain", OUTSTANDING, 0);

    // beat with nothing outstanding
    L2_DATA = {4{32'hDEAD}}; L2_DATA_VALID = 1; #1;
    chk("proto_l2_data_ready", L2_DATA_READY, 1);
    chk("proto_no_data_valid", {INS_DATA_VALID, DAT_DATA_VALID}, 0);
    chk("proto_before_edge", PROTO_ERR, 0);
    tick(); L2_DATA_VALID = 0;
    chk("proto_set", PROTO_ERR, 1);
    tick(); tick(); tick();
    chk("proto_sticky", PROTO_ERR, 1);

    // reset mid-burst
    RST = 1; tick(); RST = 0; owner_q.delete();
    chk("rst_clears_proto", PROTO_ERR, 0);
    INS_ADDR = 30'h700; exp_req(1'b0, 30'h700);
    INS_ADDR_VALID = 1; tick(); INS_ADDR_VALID = 0;
    own = owner_q.pop_front();
    send_beat(1'b1, own, {4{32'h9000}});
    send_beat(1'b1, own, {4{32'h9001}});
    chk("mid_outstanding", OUTSTANDING, 1);
    RST = 1; #1;
    chk("mid_rst_outstanding", OUTSTANDING, 0);
    chk("mid_rst_proto", PROTO_ERR, 0);
    tick(); RST = 0;
    send_beat(1'b0, 1'b0, {4{32'h9002}});
    send_beat(1'b0, 1'b0, {4{32'h9003}});
    chk("killed_beats_proto", PROTO_ERR, 1);
    chk("killed_outstanding", OUTSTANDING, 0);

    tick();
    chk("grant_queue_empty", 32'(exp_grant.size()), 0);
    chk("beat_queue_empty", 32'(exp_beat.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/l2_read_arbiter.md
# l2_read_arbiter

Shares one L2 read channel (address + burst data return) between the instruction cache miss port and the data cache read port. Arbitrates address requests, tracks owner order for up to 2^D outstanding bursts, and steers each returning L2_BURST-beat burst to the cache that issued it. Sits between the two L1 caches and the L2 / memory model, replacing two independent L2 read ports with one.

## Interface
- W, 7, L2 bus width is 2^W bits (L2_BUS_WIDTH = 1 << W)
- B, 9, cache block is 2^B bits; L2_BURST = 1 << (B - W) beats per request (B > W)
- D, 2, log2 of the outstanding-request order FIFO depth (depth = 1 << D)

- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- INS_ADDR  in  30  word address from instruction cache
- INS_ADDR_VALID  in  1  instruction request valid
- INS_ADDR_READY  out  1  instruction request accepted this cycle when high with valid
- INS_DATA  out  L2_BUS_WIDTH  burst beat to instruction cache
- INS_DATA_VALID  out  1  beat valid for instruction cache
- INS_DATA_READY  in  1  instruction cache can take a beat
- DAT_ADDR  in  30  word address from data cache
- DAT_ADDR_VALID  in  1  data request valid
- DAT_ADDR_READY  out  1  data request accepted
- DAT_DATA  out  L2_BUS_WIDTH  burst beat to data cache
- DAT_DATA_VALID  out  1  beat valid for data cache
- DAT_DATA_READY  in  1  data cache can take a beat
- L2_ADDR  out  30  address to L2
- L2_ADDR_VALID  out  1  request to L2 valid
- L2_ADDR_READY  in  1  L2 accepts request
- L2_DATA  in  L2_BUS_WIDTH  beat from L2
- L2_DATA_VALID  in  1  beat from L2 valid
- L2_DATA_READY  out  1  arbiter accepts beat
- OUTSTANDING  out  D+1  bursts issued and not fully returned
- PROTO_ERR  out  1  sticky: beat arrived with nothing outstanding

## Operation
- Address side: combinational mux of the granted requester onto L2_ADDR/L2_ADDR_VALID. Request handshake = L2_ADDR_VALID & L2_ADDR_READY; the granted requester's ADDR_READY equals L2_ADDR_READY gated by not-full; the other requester's ADDR_READY = 0.
- Grant: if only one requester valid, it wins. If both valid, the one holding priority wins. Priority register flips to the loser after every request handshake (round-robin). Reset priority: INS.
- Grant lock: once L2_ADDR_VALID is high and not accepted, grant is held until handshake, so L2_ADDR stays stable even if the other requester raises valid.
- Order FIFO (1 << D entries, 1-bit owner: 0 = INS, 1 = DAT): push owner on request handshake. When full, L2_ADDR_VALID = 0 and both ADDR_READY = 0; push is blocked when full even if a pop occurs that cycle.
- Return side: owner = FIFO head. L2_DATA routed to both DATA outputs; only the owner's DATA_VALID = L2_DATA_VALID. L2_DATA_READY = owner's DATA_READY when FIFO non-empty.
- Beat counter (B - W bits) counts beat handshakes; on beat L2_BURST - 1 it wraps to 0 and the FIFO pops. Push and pop in the same cycle leave OUTSTANDING unchanged.
- FIFO empty and L2_DATA_VALID high: L2_DATA_READY = 1 (beat discarded, no DATA_VALID asserted), PROTO_ERR set; cleared only by RST.
- RST mid-burst: FIFO, counter, priority and PROTO_ERR cleared immediately; any remaining beats of the killed burst count as protocol errors.

## Timing
- Reset values: L2_ADDR_VALID 0, INS/DAT_ADDR_READY 0 while RST is high, all DATA_VALID 0, L2_DATA_READY 0 while RST is high, OUTSTANDING 0, PROTO_ERR 0.
- Address path and data path: 0-cycle combinational latency; no buffering of beats.
- OUTSTANDING, priority, beat counter, PROTO_ERR update on the rising edge after the handshake.
- A response beat may be accepted in the same cycle as a new request handshake.

## Configuration
- L2_ARB_DAT_PRIORITY_EN defined: data cache has fixed priority whenever both are valid; the priority register is not implemented. Grant lock still applies.
- Undefined: round-robin as described in Operation.

## Test plan
- Single INS request to 0x100 (L2_BURST = 4), L2 returns 4 beats -> INS_DATA_VALID on 4 beats, DAT_DATA_VALID never, OUTSTANDING 1 then 0.
- INS and DAT valid every cycle, L2_ADDR_READY = 1 -> grants alternate INS, DAT, INS, DAT; with L2_ARB_DAT_PRIORITY_EN defined, DAT on every cycle.
- Issue 4 requests (D = 2) with no return -> 5th blocked: L2_ADDR_VALID 0, OUTSTANDING = 4; first burst completes -> 5th accepted the next cycle.
- Returns interleaved with owner order INS, DAT: DAT_DATA_READY = 0 during DAT burst -> L2_DATA_READY = 0, counter holds at its value, no beat lost.
- L2_DATA_VALID with OUTSTANDING = 0 -> L2_DATA_READY = 1, no DATA_VALID, PROTO_ERR = 1 until RST.
- RST asserted after beat 2 of a 4-beat burst -> all state zero; remaining 2 beats raise PROTO_ERR.
